// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state type and saturating add for the systolic tile controller
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } sa_state_t;

  localparam int SAT_W = 64;

  // Operands are ACC-bit values sign-extended to SAT_W; the sum is clamped to the signed w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi) return hi[SAT_W-1:0];
    if (s < lo) return lo[SAT_W-1:0];
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - output-stationary MAC cell with a/b pass-through registers
// SA_TILE_SAT_EN selects saturating accumulation instead of two's-complement wrap.
module sa_pe
  import sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] a_o,
  output logic signed [WIDTH-1:0] b_o,
  output logic signed [ACC-1:0]   acc_o
);

  logic signed [WIDTH-1:0]   a_q;
  logic signed [WIDTH-1:0]   b_q;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC-1:0]     prod_ext;
  logic signed [ACC-1:0]     acc_q;
  logic signed [ACC-1:0]     acc_d;

  assign prod     = a_i * b_i;
  assign prod_ext = ACC'(prod);

  always_comb begin
`ifdef SA_TILE_SAT_EN
    acc_d = ACC'(sat_add(64'(acc_q), 64'(prod_ext), ACC));
`else
    acc_d = acc_q + prod_ext;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_tile_ctrl.sv
// rtl/sa_tile_ctrl.sv - N x N systolic matmul tile: job FSM, skewed operand injection, row-stream output
// SA_TILE_SAT_EN (passed down to every sa_pe) enables saturating accumulation.
module sa_tile_ctrl
  import sa_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int ACC   = 32,
  parameter  int N     = 4,
  parameter  int K_MAX = 8,
  parameter  int KW    = $clog2(K_MAX + 1),
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [KW-1:0]           k_len_i,
  input  logic signed [WIDTH-1:0] a_mem_i [N][K_MAX],
  input  logic signed [WIDTH-1:0] b_mem_i [K_MAX][N],
  output logic                    busy_o,
  output logic                    c_valid_o,
  input  logic                    c_ready_i,
  output logic signed [ACC-1:0]   c_row_o [N],
  output logic [IW-1:0]           c_row_idx_o,
  output logic                    done_o
);

  localparam int TW  = $clog2(K_MAX + N + 1);
  localparam int KIW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

  sa_state_t     state_q;
  logic [KW-1:0] kl_q;
  logic [TW-1:0] t_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          c_valid_q;

  logic          pe_en;
  logic          pe_clr;
  logic          last_row;
  logic [TW-1:0] feed_last;

  logic signed [WIDTH-1:0] a_in [N];
  logic signed [WIDTH-1:0] b_in [N];
  logic signed [WIDTH-1:0] a_h  [N][N];
  logic signed [WIDTH-1:0] b_v  [N][N];
  logic signed [ACC-1:0]   acc  [N][N];

  assign pe_en     = (state_q == FEED) || (state_q == DRAIN);
  assign pe_clr    = (state_q == CLEAR);
  assign last_row  = (idx_q == IW'(N - 1));
  assign feed_last = TW'(kl_q) + TW'(N - 1) - TW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      kl_q      <= '0;
      t_q       <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      c_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            kl_q    <= (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          t_q <= '0;
          if (kl_q == '0) begin
            c_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            state_q <= FEED;
          end
        end
        FEED: begin
          if (t_q == feed_last) begin
            t_q     <= '0;
            state_q <= DRAIN;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        DRAIN: begin
          if (t_q == TW'(N - 1)) begin
            t_q       <= '0;
            c_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        OUT: begin
          if (c_ready_i) begin
            if (last_row) begin
              idx_q     <= '0;
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row i of A enters i cycles late and column j of B j cycles late, so A[i][k] meets B[k][j] at PE(i,j).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      if (state_q == FEED && t_q >= TW'(i) && (t_q - TW'(i)) < TW'(kl_q)) begin
        a_in[i] = a_mem_i[i][KIW'(t_q - TW'(i))];
        b_in[i] = b_mem_i[KIW'(t_q - TW'(i))][i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int JL = (j > 0) ? j - 1 : 0;
      localparam int IU = (i > 0) ? i - 1 : 0;
      sa_pe #(
        .WIDTH(WIDTH),
        .ACC  (ACC)
      ) u_pe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (pe_en),
        .clr_i (pe_clr),
        .a_i   ((j == 0) ? a_in[i] : a_h[i][JL]),
        .b_i   ((i == 0) ? b_in[j] : b_v[IU][j]),
        .a_o   (a_h[i][j]),
        .b_o   (b_v[i][j]),
        .acc_o (acc[i][j])
      );
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      c_row_o[j] = c_valid_q ? acc[idx_q][j] : '0;
    end
  end

  assign busy_o      = busy_q;
  assign c_valid_o   = c_valid_q;
  assign c_row_idx_o = idx_q;
  assign done_o      = c_valid_q && c_ready_i && last_row;

endmodule
